// File: rtl/rs_ff_pkg.sv
// Shared definitions for the RS latch / master-slave flip-flop block.
// Holds the S/R command encoding, the reset value and the command decoder.
package rs_ff_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_SET    = 2'b01,
        CMD_CLR    = 2'b10,
        CMD_FORBID = 2'b11
    } sr_cmd_e;

    localparam logic RST_VAL = 1'b0;

    function automatic sr_cmd_e sr_decode(
        input logic s,
        input logic r
    );
        return sr_cmd_e'({r, s});
    endfunction

endpackage

// File: rtl/rs_ff_sr_latch.sv
// Gated SR latch with asynchronous active-low clear.
// Transparent while en=1; hold and forbidden commands keep the stored value.
module sr_latch
    import rs_ff_pkg::*;
(
    input  logic en,
    input  logic s,
    input  logic r,
    input  logic rst_n,
    output logic q,
    output logic qn
);

    sr_cmd_e cmd;

    assign cmd = sr_decode(s, r);

    always_latch begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            case (cmd)
                CMD_SET: q <= 1'b1;
                CMD_CLR: q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Derived from q so the pair can never be equal, even in reset.
    assign qn = ~q;

endmodule

// File: rtl/rs_ff.sv
// Gated SR latch (Q1) and master-slave SR flip-flop (Q2) sharing S/R.
// The slave is driven from the master's complementary outputs.
module rs_ff
    import rs_ff_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    input  logic S,
    input  logic R,
    output logic Q1,
    output logic inv_Q1,
    output logic Q2,
    output logic inv_Q2
);

    logic clk_n;
    logic m_q;
    logic m_qn;

    assign clk_n = ~CLK;

    sr_latch u_q1 (
        .en    (CLK),
        .s     (S),
        .r     (R),
        .rst_n (RST_N),
        .q     (Q1),
        .qn    (inv_Q1)
    );

    sr_latch u_master (
        .en    (CLK),
        .s     (S),
        .r     (R),
        .rst_n (RST_N),
        .q     (m_q),
        .qn    (m_qn)
    );

    // Master outputs are always complementary, so the slave only sees SET/CLR.
    sr_latch u_slave (
        .en    (clk_n),
        .s     (m_q),
        .r     (m_qn),
        .rst_n (RST_N),
        .q     (Q2),
        .qn    (inv_Q2)
    );

endmodule

// File: tb/tb_rs_ff.sv
// Scoreboard bench for rs_ff: stimulus queues expected Q1/Q2,
// a monitor pops and compares after each applied step.
module tb_rs_ff;

    logic CLK;
    logic RST_N;
    logic S;
    logic R;
    logic Q1;
    logic inv_Q1;
    logic Q2;
    logic inv_Q2;

    typedef struct {
        logic  q1;
        logic  q2;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    event smp;

    rs_ff dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .S      (S),
        .R      (R),
        .Q1     (Q1),
        .inv_Q1 (inv_Q1),
        .Q2     (Q2),
        .inv_Q2 (inv_Q2)
    );

    task automatic drive(
        input logic  c,
        input logic  s_v,
        input logic  r_v,
        input logic  rn,
        input logic  e1,
        input logic  e2,
        input string nm
    );
        exp_t e;
        S     = s_v;
        R     = r_v;
        RST_N = rn;
        CLK   = c;
        #10;
        e.q1 = e1;
        e.q2 = e2;
        e.nm = nm;
        sb.push_back(e);
        -> smp;
        #10;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @smp;
            #1;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: no expected entry queued");
            end else begin
                e = sb.pop_front();
                total++;
                if (Q1 !== e.q1) begin
                    bad++;
                    $display("FAIL %s.q1 got=%b want=%b", e.nm, Q1, e.q1);
                end
                total++;
                if (Q2 !== e.q2) begin
                    bad++;
                    $display("FAIL %s.q2 got=%b want=%b", e.nm, Q2, e.q2);
                end
                total++;
                if (inv_Q1 !== ~e.q1) begin
                    bad++;
                    $display("FAIL %s.inv_q1 got=%b want=%b",
                             e.nm, inv_Q1, ~e.q1);
                end
                total++;
                if (inv_Q2 !== ~e.q2) begin
                    bad++;
                    $display("FAIL %s.inv_q2 got=%b want=%b",
                             e.nm, inv_Q2, ~e.q2);
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] q1_pat;
        logic [7:0] q2_pat;
        q1_pat = 8'b0000_1100;
        q2_pat = 8'b0001_1000;
        CLK    = 1'b1;
        S      = 1'b1;
        R      = 1'b0;
        RST_N  = 1'b0;
        #5;
        // reset dominance and release
        drive(1, 1, 0, 0, 0, 0, "rst_clk1_s1");
        drive(1, 1, 0, 1, 1, 0, "rst_release");
        drive(0, 1, 0, 1, 1, 1, "rst_first_fall");
        // latch transparency
        drive(1, 0, 0, 1, 1, 1, "lat_hold");
        drive(1, 1, 0, 1, 1, 1, "lat_s_pulse");
        drive(1, 0, 0, 1, 1, 1, "lat_s_after");
        drive(0, 0, 1, 1, 1, 1, "lat_closed_r");
        drive(1, 0, 1, 1, 0, 1, "lat_reopen");
        // master-slave
        drive(0, 0, 1, 1, 0, 0, "ms_fall_clr");
        drive(1, 1, 0, 1, 1, 0, "ms_high_hold");
        drive(0, 1, 0, 1, 1, 1, "ms_fall_set");
        drive(0, 0, 1, 1, 1, 1, "ms_low_ignore");
        drive(1, 0, 1, 1, 0, 1, "ms_rise_clr");
        drive(0, 0, 1, 1, 0, 0, "ms_fall_clr2");
        // forbidden input
        drive(1, 1, 0, 1, 1, 0, "fb_prep_set");
        drive(0, 1, 0, 1, 1, 1, "fb_prep_fall");
        drive(0, 1, 1, 1, 1, 1, "fb_low");
        drive(1, 1, 1, 1, 1, 1, "fb_high");
        drive(0, 1, 1, 1, 1, 1, "fb_fall");
        // async reset with CLK low discards master
        drive(0, 0, 0, 0, 0, 0, "arst_lo");
        drive(0, 0, 0, 1, 0, 0, "arst_lo_rel");
        drive(1, 0, 0, 1, 0, 0, "arst_lo_rise");
        drive(0, 0, 0, 1, 0, 0, "arst_lo_fall");
        // async reset with CLK high discards master
        drive(1, 1, 0, 1, 1, 0, "arst_hi_prep");
        drive(1, 0, 0, 0, 0, 0, "arst_hi");
        drive(1, 0, 0, 1, 0, 0, "arst_hi_rel");
        drive(0, 0, 0, 1, 0, 0, "arst_hi_fall");
        // S/R changing together with a CLK edge
        drive(1, 0, 0, 1, 0, 0, "edge_prep_rise");
        drive(0, 1, 0, 1, 0, 0, "edge_fall_same");
        drive(1, 0, 0, 1, 0, 0, "edge_rise_same");
        drive(0, 0, 0, 1, 0, 0, "edge_prep_fall");
        drive(1, 1, 0, 1, 1, 0, "edge_rise_new");
        drive(0, 0, 1, 1, 1, 1, "edge_fall_pre");
        // free-running: CLK 100ns, S 200ns, R 400ns
        drive(1, 0, 0, 0, 0, 0, "fr_reset");
        RST_N = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_t e;
            S   = ((k / 2) % 2) == 1;
            R   = ((k / 4) % 2) == 1;
            CLK = (k % 2) == 0;
            #50;
            e.q1 = q1_pat[k % 8];
            e.q2 = q2_pat[k % 8];
            e.nm = $sformatf("fr_%0d", k);
            sb.push_back(e);
            -> smp;
            #50;
        end
        for (int i = 0; i < 100 && sb.size() != 0; i++) #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
